// File: rtl/pio_edge_irq_multi.sv
// pio_edge_irq_multi
//   Multi-bit input PIO for the Nios Avalon-MM interconnect. Each input bit is
//   synchronised and optionally debounced. Its edge, falling or rising as
//   selected per bit, is captured in a sticky register. Interrupts are raised
//   for captured bits that are enabled in the mask.
//
//   Optional build macro: PIO_DEBOUNCE_EN adds a per-bit stability filter of
//   DEBOUNCE_CYCLES cycles between the synchroniser and the edge detector.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select: 0 data (RO), 1 polarity, 2 irq_mask,
//               3 edge_capture (write-1-to-clear)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, WIDTH bits
//   in_port     asynchronous external inputs, WIDTH bits
//   readdata    registered read data, one cycle after address
//   irq         level interrupt, |(edge_capture & irq_mask)
module pio_edge_irq_multi #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] POL_RESET       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_p1;
    logic [WIDTH-1:0] s2_p2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] polarity;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // Stage p1/p2: two-flop synchroniser on the raw inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_p1 <= '0;
            s2_p2 <= '0;
        end else begin
            s1_p1 <= in_port;
            s2_p2 <= s1_p1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;

    // Filter stage: the filtered level follows s2 only after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt       <= '0;
                filt_q[i] <= 1'b0;
            end else if (s2_p2[i] == filt_q[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                filt_q[i] <= s2_p2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_p2;
`endif

    // Edge stage: previous filtered level for per-bit edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d <= '0;
        end else begin
            filt_d <= filt;
        end
    end

    // polarity 1 selects rising edges, 0 selects falling edges
    assign edge_det = (polarity & filt & ~filt_d) | (~polarity & filt_d & ~filt);

    assign clr_mask = (wr_en && address == 2'd3) ? writedata : '0;

    // Capture stage: the clear is applied first so a same-cycle edge keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr_mask) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            polarity <= POL_RESET;
            irq_mask <= '0;
        end else begin
            if (wr_en && address == 2'd1) begin
                polarity <= writedata;
            end
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata;
            end
        end
    end

    // Read stage: the mux is registered every cycle, regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= filt;
                2'd1:    readdata <= polarity;
                2'd2:    readdata <= irq_mask;
                default: readdata <= edge_capture;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
